// File: rtl/m_cache_assoc.sv
// ---------------------------------------------------------------------------
// m_cache_assoc
// 2-way set-associative, 4-word/line, write-through, write-no-allocate cache
// with one LRU bit per set. Tag, valid and data live in synchronous-read
// arrays read on the request-accept edge. After reset or flush an INIT sweep
// clears one set per cycle before requests are accepted.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_req/i_we/i_addr/i_wdata CPU request (accepted when i_req && o_ready)
//   i_flush                   invalidate-all request (honoured in IDLE only)
//   o_ready                   cache can accept a request this cycle
//   o_rvalid/o_rdata          one-cycle read-data pulse
//   o_mreq/o_mwe/o_maddr/     memory request: line read (o_mwe=0) or
//   o_mwdata                  single-word write-through (o_mwe=1)
//   i_mack                    memory accepted o_mreq
//   i_mrvalid/i_mrdata        refill line, word w at bits [32w+31:32w]
// ---------------------------------------------------------------------------
module m_cache_assoc #(
   parameter int ADDR_WIDTH  = 32,
   parameter int INDEX_WIDTH = 6
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_req,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [31:0]           i_wdata,
   input  logic                  i_flush,
   output logic                  o_ready,
   output logic                  o_rvalid,
   output logic [31:0]           o_rdata,
   output logic                  o_mreq,
   output logic                  o_mwe,
   output logic [ADDR_WIDTH-1:0] o_maddr,
   output logic [31:0]           o_mwdata,
   input  logic                  i_mack,
   input  logic                  i_mrvalid,
   input  logic [127:0]          i_mrdata
);

   localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 4;
   localparam int SETS      = 1 << INDEX_WIDTH;
   localparam logic [INDEX_WIDTH-1:0] LAST_SET = '1;

   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_LOOKUP, S_MREQ, S_MWAIT, S_WMEM
   } state_e;

   state_e                  state_q, state_d;
   logic [INDEX_WIDTH-1:0]  cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    we_q, we_d;
   logic [31:0]             wdata_q, wdata_d;

   // Storage arrays and their registered read ports
   logic [TAG_WIDTH-1:0]    tag_mem   [2][SETS];
   logic                    valid_mem [2][SETS];
   logic [127:0]            data_mem  [2][SETS];
   logic                    lru_mem   [SETS];

   logic [TAG_WIDTH-1:0]    tag_rd_q   [2];
   logic [1:0]              valid_rd_q;
   logic [127:0]            data_rd_q  [2];

   logic [INDEX_WIDTH-1:0]  acc_idx, idx_q;
   logic [TAG_WIDTH-1:0]    tag_q;
   logic [1:0]              word_sel;
   logic [1:0]              hit_way;
   logic                    hit, hit_idx, victim;
   logic                    accept, init_clr, lookup_hit, wr_hit, refill;
   logic [127:0]            hit_line;
   logic [31:0]             hit_word, refill_word;

   assign acc_idx  = i_addr[INDEX_WIDTH+3:4];
   assign idx_q    = addr_q[INDEX_WIDTH+3:4];
   assign tag_q    = addr_q[ADDR_WIDTH-1:INDEX_WIDTH+4];
   assign word_sel = addr_q[3:2];

   assign hit_way[0] = valid_rd_q[0] && (tag_rd_q[0] == tag_q);
   assign hit_way[1] = valid_rd_q[1] && (tag_rd_q[1] == tag_q);
   assign hit        = |hit_way;
   // Only one way can hold a given tag, so way 1's hit bit names the hit way.
   assign hit_idx    = hit_way[1];

   // Fill invalid ways first (way 0 preferred), otherwise evict the LRU way.
   assign victim = !valid_rd_q[0] ? 1'b0 :
                   !valid_rd_q[1] ? 1'b1 : lru_mem[idx_q];

   assign accept     = (state_q == S_IDLE) && i_req && !i_flush;
   assign init_clr   = (state_q == S_INIT);
   assign lookup_hit = (state_q == S_LOOKUP) && hit;
   assign wr_hit     = lookup_hit && we_q;
   assign refill     = (state_q == S_MWAIT) && i_mrvalid;

   assign hit_line    = hit_idx ? data_rd_q[1] : data_rd_q[0];
   assign hit_word    = hit_line[{word_sel, 5'b00000} +: 32];
   assign refill_word = i_mrdata[{word_sel, 5'b00000} +: 32];

   // NOTE: storage arrays carry no reset; the INIT sweep clears the valid and
   // LRU bits, and tag/data contents are meaningless while valid is 0.
   always_ff @(posedge i_clk) begin
      if (accept) begin
         for (int w = 0; w < 2; w++) begin
            tag_rd_q[w]   <= tag_mem[w][acc_idx];
            valid_rd_q[w] <= valid_mem[w][acc_idx];
            data_rd_q[w]  <= data_mem[w][acc_idx];
         end
      end
      if (init_clr) begin
         valid_mem[0][cnt_q] <= 1'b0;
         valid_mem[1][cnt_q] <= 1'b0;
         lru_mem[cnt_q]      <= 1'b0;
      end
      if (lookup_hit) begin
         lru_mem[idx_q] <= ~hit_idx;
      end
      if (wr_hit) begin
         data_mem[hit_idx][idx_q][{word_sel, 5'b00000} +: 32] <= wdata_q;
      end
      if (refill) begin
         data_mem[victim][idx_q]  <= i_mrdata;
         tag_mem[victim][idx_q]   <= tag_q;
         valid_mem[victim][idx_q] <= 1'b1;
         lru_mem[idx_q]           <= ~victim;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of its peers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
      end
   end

   // NOTE: every output and next-state value gets a default first so no
   // branch of the case statement can infer a latch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      we_d     = we_q;
      wdata_d  = wdata_q;
      o_ready  = 1'b0;
      o_rvalid = 1'b0;
      o_rdata  = '0;
      o_mreq   = 1'b0;
      o_mwe    = 1'b0;
      o_maddr  = '0;
      o_mwdata = '0;

      case (state_q)
         S_INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_SET) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         S_IDLE: begin
            o_ready = !i_flush;
            if (i_flush) begin
               cnt_d   = '0;
               state_d = S_INIT;
            end else if (i_req) begin
               addr_d  = i_addr;
               we_d    = i_we;
               wdata_d = i_wdata;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (we_q) begin
               state_d = S_WMEM;
            end else if (hit) begin
               o_rvalid = 1'b1;
               o_rdata  = hit_word;
               state_d  = S_IDLE;
            end else begin
               state_d = S_MREQ;
            end
         end
         S_MREQ: begin
            o_mreq  = 1'b1;
            o_maddr = {addr_q[ADDR_WIDTH-1:4], 4'b0000};
            if (i_mack) state_d = S_MWAIT;
         end
         S_MWAIT: begin
            if (i_mrvalid) begin
               o_rvalid = 1'b1;
               o_rdata  = refill_word;
               state_d  = S_IDLE;
            end
         end
         S_WMEM: begin
            o_mreq   = 1'b1;
            o_mwe    = 1'b1;
            o_maddr  = addr_q;
            o_mwdata = wdata_q;
            if (i_mack) state_d = S_IDLE;
         end
         default: state_d = S_INIT;
      endcase
   end

endmodule

// File: tb/tb_m_cache_assoc.sv
// ---------------------------------------------------------------------------
// tb_m_cache_assoc
// Self-checking bench for m_cache_assoc (INDEX_WIDTH=6). A table of CPU
// transactions is applied in a loop; the bench plays the memory, keeps a
// word-level backing-store model, and pushes expected read data into a
// scoreboard queue that is popped whenever o_rvalid is seen. Hand-written
// sequences cover reset release, flush and reset in the middle of a miss.
// ---------------------------------------------------------------------------
module tb_m_cache_assoc;

   logic         i_clk = 1'b0;
   logic         i_rst_n;
   logic         i_req, i_we, i_flush, i_mack, i_mrvalid;
   logic [31:0]  i_addr, i_wdata;
   logic [127:0] i_mrdata;
   logic         o_ready, o_rvalid, o_mreq, o_mwe;
   logic [31:0]  o_rdata, o_maddr, o_mwdata;

   m_cache_assoc #(.ADDR_WIDTH(32), .INDEX_WIDTH(6)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
      .i_flush(i_flush),
      .o_ready(o_ready), .o_rvalid(o_rvalid), .o_rdata(o_rdata),
      .o_mreq(o_mreq), .o_mwe(o_mwe), .o_maddr(o_maddr), .o_mwdata(o_mwdata),
      .i_mack(i_mack), .i_mrvalid(i_mrvalid), .i_mrdata(i_mrdata)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          exp_hit;
      int          dly;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] sb_q[$];
   logic [31:0] mem_model [logic [31:0]];
   vec_t        vecs [14];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   function automatic logic [31:0] model_word(input logic [31:0] a);
      logic [31:0] wa;
      wa = {a[31:2], 2'b00};
      if (mem_model.exists(wa)) return mem_model[wa];
      return {wa[15:0], 16'h5A5A} ^ 32'h0F0F_0000;
   endfunction

   function automatic logic [127:0] model_line(input logic [31:0] a);
      logic [31:0] b;
      b = {a[31:4], 4'h0};
      return {model_word(b + 32'd12), model_word(b + 32'd8),
              model_word(b + 32'd4), model_word(b)};
   endfunction

   function automatic logic [127:0] out_bundle();
      return {o_ready, o_rvalid, o_mreq, o_mwe, o_maddr, o_mwdata, o_rdata};
   endfunction

   task automatic wait_ready(input string name);
      int n;
      n = 0;
      @(negedge i_clk);
      while (!o_ready && n < 200) begin
         @(negedge i_clk);
         n++;
      end
      if (!o_ready) timeout_fail({name, " ready"});
   endtask

   task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input string name);
      wait_ready(name);
      i_req   = 1'b1;
      i_we    = we;
      i_addr  = addr;
      i_wdata = wdata;
      @(posedge i_clk);
      #1;
      i_req = 1'b0;
      i_we  = 1'b0;
   endtask

   task automatic pop_compare(input string name);
      logic [31:0] exp;
      if (sb_q.size() == 0) begin
         timeout_fail({name, " unexpected rvalid"});
      end else begin
         exp = sb_q.pop_front();
         check({name, " rdata"}, o_rdata, exp);
      end
   endtask

   task automatic do_read(input logic [31:0] addr, input bit exp_hit, input int dly,
                          input string name);
      int n;
      issue(1'b0, addr, 32'h0, name);
      sb_q.push_back(model_word(addr));
      @(negedge i_clk);
      check({name, " hit"}, o_rvalid, exp_hit);
      if (o_rvalid) begin
         check({name, " no mreq on hit"}, o_mreq, 1'b0);
         pop_compare(name);
      end else begin
         n = 0;
         while (!o_mreq && n < 20) begin
            @(negedge i_clk);
            n++;
         end
         if (!o_mreq) begin
            timeout_fail({name, " mreq"});
            void'(sb_q.pop_front());
         end else begin
            check({name, " mreq"}, {o_mwe, o_maddr}, {1'b0, addr[31:4], 4'h0});
            repeat (dly) @(negedge i_clk);
            check({name, " mreq held"}, {o_mreq, o_mwe, o_maddr}, {2'b10, addr[31:4], 4'h0});
            i_mack = 1'b1;
            @(negedge i_clk);
            i_mack = 1'b0;
            check({name, " mwait quiet"}, {o_mreq, o_rvalid}, 2'b00);
            repeat (dly) @(negedge i_clk);
            i_mrvalid = 1'b1;
            i_mrdata  = model_line(addr);
            #1;
            check({name, " refill rvalid"}, o_rvalid, 1'b1);
            if (o_rvalid) pop_compare(name);
            else void'(sb_q.pop_front());
            @(negedge i_clk);
            i_mrvalid = 1'b0;
            i_mrdata  = '0;
         end
      end
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] wdata, input int dly,
                           input string name);
      int n;
      issue(1'b1, addr, wdata, name);
      @(negedge i_clk);
      check({name, " lookup quiet"}, {o_mreq, o_rvalid}, 2'b00);
      n = 0;
      @(negedge i_clk);
      while (!o_mreq && n < 20) begin
         @(negedge i_clk);
         n++;
      end
      if (!o_mreq) begin
         timeout_fail({name, " wmem"});
      end else begin
         check({name, " wmem"}, {o_mwe, o_maddr, o_mwdata}, {1'b1, addr, wdata});
         repeat (dly) @(negedge i_clk);
         check({name, " wmem held"}, {o_mreq, o_mwe, o_maddr, o_mwdata, o_rvalid},
               {2'b11, addr, wdata, 1'b0});
         mem_model[{addr[31:2], 2'b00}] = wdata;
         i_mack = 1'b1;
         @(negedge i_clk);
         i_mack = 1'b0;
         check({name, " back to idle"}, {o_ready, o_mreq, o_rvalid}, 3'b100);
      end
   endtask

   // Counts consecutive cycles with o_ready low, starting at the current
   // sample; optionally drives a stray refill pulse partway through.
   task automatic count_sweep(input bit pulse, output int n, output int stray);
      n = 0;
      stray = 0;
      while (!o_ready && n < 200) begin
         n++;
         if (o_rvalid || o_mreq) stray++;
         @(negedge i_clk);
         i_mrvalid = pulse && (n == 2);
         i_mrdata  = {4{32'hDEAD_BEEF}};
         #1;
      end
      i_mrvalid = 1'b0;
      i_mrdata  = '0;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, stray;

      vecs[0]  = '{1'b0, 32'h0000_1004, 32'h0,         1'b0, 0};
      vecs[1]  = '{1'b0, 32'h0000_1004, 32'h0,         1'b1, 0};
      vecs[2]  = '{1'b0, 32'h0000_2000, 32'h0,         1'b0, 1};
      vecs[3]  = '{1'b0, 32'h0000_1000, 32'h0,         1'b1, 0};
      vecs[4]  = '{1'b0, 32'h0000_3000, 32'h0,         1'b0, 0};
      vecs[5]  = '{1'b0, 32'h0000_1000, 32'h0,         1'b1, 0};
      vecs[6]  = '{1'b0, 32'h0000_2000, 32'h0,         1'b0, 2};
      vecs[7]  = '{1'b1, 32'h0000_1008, 32'h0000_CAFE, 1'b1, 2};
      vecs[8]  = '{1'b0, 32'h0000_1008, 32'h0,         1'b1, 0};
      vecs[9]  = '{1'b1, 32'h0000_5000, 32'h0000_1234, 1'b0, 0};
      vecs[10] = '{1'b0, 32'h0000_5000, 32'h0,         1'b0, 0};
      vecs[11] = '{1'b0, 32'h0000_5000, 32'h0,         1'b1, 0};
      vecs[12] = '{1'b0, 32'h0000_1014, 32'h0,         1'b0, 1};
      vecs[13] = '{1'b0, 32'h0000_101C, 32'h0,         1'b1, 0};

      mem_model[32'h1000] = 32'hA;
      mem_model[32'h1004] = 32'hB;
      mem_model[32'h1008] = 32'hC;
      mem_model[32'h100C] = 32'hD;

      i_rst_n = 1'b0; i_req = 1'b0; i_we = 1'b0; i_flush = 1'b0;
      i_mack = 1'b0; i_mrvalid = 1'b0; i_addr = '0; i_wdata = '0; i_mrdata = '0;

      repeat (3) @(negedge i_clk);
      check("reset outputs", out_bundle(), '0);
      i_rst_n = 1'b1;
      #1;
      count_sweep(1'b0, n, stray);
      check("reset sweep length", n, 64);

      foreach (vecs[i]) begin
         if (vecs[i].we)
            do_write(vecs[i].addr, vecs[i].wdata, vecs[i].dly, $sformatf("v%0d", i));
         else
            do_read(vecs[i].addr, vecs[i].exp_hit, vecs[i].dly, $sformatf("v%0d", i));
      end

      // Flush in IDLE with a request present: the request is dropped.
      wait_ready("flush");
      i_flush = 1'b1;
      i_req   = 1'b1;
      i_addr  = 32'h0000_1000;
      #1;
      check("flush ready low", o_ready, 1'b0);
      @(negedge i_clk);
      i_flush = 1'b0;
      i_req   = 1'b0;
      #1;
      count_sweep(1'b0, n, stray);
      check("flush sweep length", n, 64);
      check("flush sweep quiet", stray, 0);
      do_read(32'h0000_1000, 1'b0, 0, "post-flush");
      do_read(32'h0000_1000, 1'b1, 0, "post-flush again");

      // Reset while the line request is outstanding in MREQ.
      issue(1'b0, 32'h0000_7080, 32'h0, "rst-mreq");
      n = 0;
      @(negedge i_clk);
      while (!o_mreq && n < 20) begin
         @(negedge i_clk);
         n++;
      end
      check("rst-mreq reached", o_mreq, 1'b1);
      i_rst_n = 1'b0;
      #1;
      check("rst-mreq outputs", out_bundle(), '0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      #1;
      count_sweep(1'b0, n, stray);
      check("rst-mreq sweep length", n, 64);

      // Reset in MWAIT, then a late refill pulse during the sweep.
      issue(1'b0, 32'h0000_7040, 32'h0, "rst-mwait");
      n = 0;
      @(negedge i_clk);
      while (!o_mreq && n < 20) begin
         @(negedge i_clk);
         n++;
      end
      i_mack = 1'b1;
      @(negedge i_clk);
      i_mack  = 1'b0;
      i_rst_n = 1'b0;
      #1;
      check("rst-mwait outputs", out_bundle(), '0);
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
      #1;
      count_sweep(1'b1, n, stray);
      check("rst-mwait sweep length", n, 64);
      check("rst-mwait stray refill ignored", stray, 0);
      do_read(32'h0000_7040, 1'b0, 0, "after abandoned refill");
      do_read(32'h0000_1004, 1'b0, 0, "valid cleared by reset");

      check("scoreboard drained", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
